// File: rtl/id_ex_stage_buffer_pkg.sv
// id_ex_stage_buffer_pkg: shared opcode constants, FSM states and payload type for the ID->EX stage
package proc_pipe_pkg;
  localparam int DEF_DW = 16;
  localparam int DEF_IMMW = 32;
  localparam int DEF_OPW = 4;
  localparam int DEF_RAW = 3;
  localparam logic [DEF_OPW-1:0] OP_NOP = 4'd0;
  localparam logic [DEF_OPW-1:0] OP_ADD = 4'd1;
  localparam logic [DEF_OPW-1:0] OP_SUB = 4'd2;
  localparam logic [DEF_OPW-1:0] OP_AND = 4'd3;
  localparam logic [DEF_OPW-1:0] OP_OR = 4'd4;
  localparam logic [DEF_OPW-1:0] OP_LW = 4'd5;
  localparam logic [DEF_OPW-1:0] OP_SW = 4'd6;
  localparam logic [DEF_OPW-1:0] OP_BEQ = 4'd7;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
  typedef struct packed {
    logic [DEF_OPW-1:0] opcode;
    logic [DEF_DW-1:0] rd1;
    logic [DEF_DW-1:0] rd2;
    logic [DEF_IMMW-1:0] imm;
    logic [DEF_RAW-1:0] rd_addr;
  } id_ex_payload_t;
endpackage

// File: rtl/id_ex_stage_buffer_if.sv
// id_ex_stage_buffer_if: ID-side and EX-side handshake plus payload bundle of the ID->EX stage
interface id_ex_stage_buffer_if #(
  parameter int DW = proc_pipe_pkg::DEF_DW,
  parameter int IMMW = proc_pipe_pkg::DEF_IMMW,
  parameter int OPW = proc_pipe_pkg::DEF_OPW,
  parameter int RAW = proc_pipe_pkg::DEF_RAW
);
  logic in_valid;
  logic in_ready;
  logic [OPW-1:0] opcode;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic [IMMW-1:0] extended_signal;
  logic [RAW-1:0] rd_addr;
  logic out_valid;
  logic out_ready;
  logic [OPW-1:0] opcode_out;
  logic [DW-1:0] dataRFOut1;
  logic [DW-1:0] dataRFOut2;
  logic [IMMW-1:0] imm_out;
  logic [RAW-1:0] rd_addr_out;
  modport master (
    output in_valid, opcode, read_data1, read_data2, extended_signal, rd_addr, out_ready,
    input in_ready, out_valid, opcode_out, dataRFOut1, dataRFOut2, imm_out, rd_addr_out
  );
  modport slave (
    input in_valid, opcode, read_data1, read_data2, extended_signal, rd_addr, out_ready,
    output in_ready, out_valid, opcode_out, dataRFOut1, dataRFOut2, imm_out, rd_addr_out
  );
endinterface

// File: rtl/id_ex_stage_buffer_entry.sv
// id_ex_entry: one payload register with load enable and synchronous clear
module id_ex_entry #(
  parameter int W = 71
) (
  input logic clock,
  input logic reset,
  input logic load,
  input logic clear,
  input logic [W-1:0] d,
  output logic [W-1:0] q
);
  // clear wins over load so a squash never leaves a partial entry behind
  always_ff @(posedge clock or negedge reset)
    if (!reset) q <= '0;
    else if (clear) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/id_ex_stage_buffer.sv
// id_ex_stage_buffer: ID->EX stage with valid/ready, 2-entry skid, flush and bubbles; IDEX_PERF_COUNT_EN adds perf counters
module id_ex_stage_buffer
  import proc_pipe_pkg::*;
#(
  parameter int DW = 16,
  parameter int IMMW = 32,
  parameter int OPW = 4,
  parameter int RAW = 3
) (
  input logic clock,
  input logic reset,
  input logic flush,
  id_ex_stage_buffer_if.slave bus
`ifdef IDEX_PERF_COUNT_EN
  ,
  output logic [31:0] bubble_count,
  output logic [31:0] stall_count
`endif
);
  localparam int PW = OPW + 2 * DW + IMMW + RAW;
  buf_state_t state, state_nx;
  logic accept, consume, main_load, main_from_skid, skid_load;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q, out_pl;
  assign in_pl = {bus.opcode, bus.read_data1, bus.read_data2, bus.extended_signal, bus.rd_addr};
  assign bus.in_ready = state != FULL;
  assign bus.out_valid = state != EMPTY;
  assign accept = bus.in_valid & bus.in_ready;
  assign consume = bus.out_valid & bus.out_ready;
  assign main_d = main_from_skid ? skid_q : in_pl;
  assign out_pl = bus.out_valid ? main_q : '0;
  assign {bus.opcode_out, bus.dataRFOut1, bus.dataRFOut2, bus.imm_out, bus.rd_addr_out} = out_pl;
  // occupancy state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= EMPTY;
    else state <= state_nx;
  // next occupancy and entry load controls; flush overrides every transfer
  always_comb begin
    state_nx = state;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: if (accept) begin
        main_load = 1'b1;
        state_nx = ONE;
      end
      ONE: if (accept) begin
        main_load = consume;
        skid_load = !consume;
        state_nx = consume ? ONE : FULL;
      end else if (consume) state_nx = EMPTY;
      FULL: if (consume) begin
        main_load = 1'b1;
        main_from_skid = 1'b1;
        state_nx = ONE;
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end
  id_ex_entry #(.W(PW)) u_main (
    .clock(clock), .reset(reset), .load(main_load), .clear(flush), .d(main_d), .q(main_q)
  );
  id_ex_entry #(.W(PW)) u_skid (
    .clock(clock), .reset(reset), .load(skid_load), .clear(flush), .d(in_pl), .q(skid_q)
  );
`ifdef IDEX_PERF_COUNT_EN
  // free-running wrap-around counters of EX starvation and ID stalls
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      bubble_count <= '0;
      stall_count <= '0;
    end else begin
      bubble_count <= bubble_count + {31'd0, bus.out_ready & !bus.out_valid};
      stall_count <= stall_count + {31'd0, bus.in_valid & !bus.in_ready};
    end
`endif
endmodule

// File: tb/tb_id_ex_stage_buffer.sv
// tb_id_ex_stage_buffer: scoreboard bench for the ID->EX stage buffer
module tb_id_ex_stage_buffer;
  import proc_pipe_pkg::*;
  logic clock = 0;
  logic reset = 0;
  logic flush = 0;
  int compared = 0;
  int mismatched = 0;
  id_ex_payload_t exp_q[$];
  id_ex_payload_t got, e, p5;
  logic acc;
  always #5 clock = ~clock;
  id_ex_stage_buffer_if bif ();
`ifdef IDEX_PERF_COUNT_EN
  logic [31:0] bubble_count, stall_count;
`endif
  id_ex_stage_buffer u_dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .bus(bif)
`ifdef IDEX_PERF_COUNT_EN
    ,
    .bubble_count(bubble_count),
    .stall_count(stall_count)
`endif
  );

  function automatic id_ex_payload_t mk(input logic [3:0] op);
    id_ex_payload_t r;
    r.opcode = op;
    r.rd1 = {4{op}};
    r.rd2 = ~{4{op}};
    r.imm = {8{op}};
    r.rd_addr = op[2:0];
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] w);
    compared++;
    if (g !== w) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, g, w);
    end
  endtask

  // monitor: pop and compare on every consume, bubbles must carry an all-zero payload
  always @(negedge clock)
    if (reset) begin
      got = {bif.opcode_out, bif.dataRFOut1, bif.dataRFOut2, bif.imm_out, bif.rd_addr_out};
      if (bif.out_valid && bif.out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_output: got %0h expected nothing", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            mismatched++;
            $display("FAIL out_payload: got %0h expected %0h", got, e);
          end
        end
      end else if (!bif.out_valid) begin
        compared++;
        if (got !== '0) begin
          mismatched++;
          $display("FAIL bubble_payload: got %0h expected 0", got);
        end
      end
    end

  task automatic cyc(input logic v, input id_ex_payload_t p, input logic ordy, input logic fl,
                     output logic a);
    bif.in_valid = v;
    {bif.opcode, bif.read_data1, bif.read_data2, bif.extended_signal, bif.rd_addr} = p;
    bif.out_ready = ordy;
    flush = fl;
    @(negedge clock);
    a = v & bif.in_ready & !fl;
    if (a) exp_q.push_back(p);
    if (fl) exp_q.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input id_ex_payload_t p, input logic ordy);
    logic a;
    a = 0;
    for (int i = 0; i < 20 && !a; i++) cyc(1, p, ordy, 0, a);
    if (!a) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got not accepted expected accept of op %0h", p.opcode);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.in_valid = 0;
    bif.out_ready = 0;
    {bif.opcode, bif.read_data1, bif.read_data2, bif.extended_signal, bif.rd_addr} = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1;
    chk("reset_out_valid", bif.out_valid, 0);
    chk("reset_in_ready", bif.in_ready, 1);
    // stream 1..8 with EX always ready
    for (int op = 1; op <= 8; op++) begin
      cyc(1, mk(4'(op)), 1, 0, acc);
      chk("stream_accept", acc, 1);
      chk("stream_lag_valid", bif.out_valid, 1);
      chk("stream_lag_op", bif.opcode_out, op);
    end
    cyc(0, mk(0), 1, 0, acc);
    chk("stream_drained", exp_q.size(), 0);
    // backpressure: 3 and 5 fill the stage, 7 must wait
    cyc(1, mk(3), 0, 0, acc);
    cyc(1, mk(5), 0, 0, acc);
    cyc(1, mk(7), 0, 0, acc);
    chk("bp_held", acc, 0);
    chk("bp_in_ready", bif.in_ready, 0);
    chk("bp_head_op", bif.opcode_out, 3);
    send(mk(7), 1);
    cyc(0, mk(0), 1, 0, acc);
    chk("bp_drained", exp_q.size(), 0);
    // flush while full and while op 9 is offered
    cyc(1, mk(1), 0, 0, acc);
    cyc(1, mk(2), 0, 0, acc);
    cyc(1, mk(9), 0, 1, acc);
    chk("flush_out_valid", bif.out_valid, 0);
    chk("flush_opcode", bif.opcode_out, 0);
    chk("flush_in_ready", bif.in_ready, 1);
    cyc(1, mk(4), 1, 0, acc);
    chk("post_flush_accept", acc, 1);
    chk("post_flush_valid", bif.out_valid, 1);
    chk("post_flush_op", bif.opcode_out, 4);
    cyc(0, mk(0), 1, 0, acc);
    chk("flush_drained", exp_q.size(), 0);
    // bit-exact data fields
    p5.opcode = 4'd2;
    p5.rd1 = 16'hA5A5;
    p5.rd2 = 16'h5A5A;
    p5.imm = 32'hFFFF_FF80;
    p5.rd_addr = 3'd6;
    send(p5, 1);
    chk("data_rd1", bif.dataRFOut1, 32'hA5A5);
    chk("data_rd2", bif.dataRFOut2, 32'h5A5A);
    chk("data_imm", bif.imm_out, 32'hFFFF_FF80);
    chk("data_rd_addr", bif.rd_addr_out, 6);
    cyc(0, mk(0), 1, 0, acc);
    // asynchronous reset with the stage full
    cyc(1, mk(6), 0, 0, acc);
    cyc(1, mk(7), 0, 0, acc);
    #2 reset = 0;
    bif.in_valid = 0;
    bif.out_ready = 0;
    #1;
    chk("areset_out_valid", bif.out_valid, 0);
    chk("areset_opcode", bif.opcode_out, 0);
    chk("areset_rd1", bif.dataRFOut1, 0);
    chk("areset_rd2", bif.dataRFOut2, 0);
    chk("areset_in_ready", bif.in_ready, 1);
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1;
    // 3 bubble cycles, then fill and stall ID for 4 cycles
    repeat (3) cyc(0, mk(0), 1, 0, acc);
    cyc(1, mk(1), 0, 0, acc);
    cyc(1, mk(2), 0, 0, acc);
    repeat (4) cyc(1, mk(3), 0, 0, acc);
    chk("perf_full_in_ready", bif.in_ready, 0);
`ifdef IDEX_PERF_COUNT_EN
    chk("perf_stall_count", stall_count, 4);
    chk("perf_bubble_count", bubble_count, 3);
`endif
    cyc(0, mk(0), 0, 1, acc);
    chk("final_out_valid", bif.out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
